// File: rtl/reg_read_sequencer.sv
// Operand-fetch sequencer: takes a LEGv8 word and reads Rn and Rm/Rt through a register-file port with one cycle of latency.
// It then holds the operands until the consumer accepts them. Option: SEQ_BYPASS_EN lets the next accept overlap the op handshake.
module reg_read_sequencer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        rd_addr,
  output logic              reg2loc,
  input  logic [DATA_W-1:0] rd_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [4:0]        op_dst
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t            state_q, state_d, first_state;
  logic [4:0]        rn_q, rn_d, rm_q, rm_d, dst_q, dst_d;
  logic              need_a_q, need_a_d, need_b_q, need_b_d;
  logic              reg2loc_q, reg2loc_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              dec_need_a, dec_need_b, dec_reg2loc;
  logic              accept;
  logic              unused_instr_bits;

  // Shamt / imm bits [15:10] never select a register.
  assign unused_instr_bits = ^instr[15:10];
  assign accept            = instr_valid & instr_ready;

  // Decode of the word on the instr port; only consulted on an accept edge.
  always_comb begin
    dec_need_a  = 1'b1;
    dec_need_b  = 1'b1;
    dec_reg2loc = 1'b0;
    if (instr[31:21] == 11'h7C0) begin
      dec_reg2loc = 1'b1;
    end else if (instr[31:21] == 11'h7C2) begin
      dec_need_b = 1'b0;
    end else if (instr[31:24] == 8'hB4) begin
      dec_need_a  = 1'b0;
      dec_reg2loc = 1'b1;
    end else if (instr[31:26] == 6'b000101) begin
      dec_need_a = 1'b0;
      dec_need_b = 1'b0;
    end
    if (dec_need_a) begin
      first_state = RD_A;
    end else if (dec_need_b) begin
      first_state = RD_B;
    end else begin
      first_state = OUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = first_state;
      RD_A:    state_d = need_b_q ? RD_B : CAP;
      RD_B:    state_d = CAP;
      CAP:     state_d = OUT;
      OUT:     if (op_ready) state_d = accept ? first_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rn_d      = rn_q;
    rm_d      = rm_q;
    dst_d     = dst_q;
    need_a_d  = need_a_q;
    need_b_d  = need_b_q;
    reg2loc_d = reg2loc_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    if (accept) begin
      rn_d      = instr[9:5];
      rm_d      = instr[20:16];
      dst_d     = instr[4:0];
      need_a_d  = dec_need_a;
      need_b_d  = dec_need_b;
      reg2loc_d = dec_reg2loc;
      op_a_d    = '0;
      op_b_d    = '0;
    end else begin
      case (state_q)
        // rd_data here answers the RD_A address issued last cycle.
        RD_B:    if (need_a_q) op_a_d = rd_data;
        CAP: begin
          if (need_b_q) begin
            op_b_d = rd_data;
          end else begin
            op_a_d = rd_data;
          end
        end
        OUT:     if (op_ready) reg2loc_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rn_q      <= '0;
      rm_q      <= '0;
      dst_q     <= '0;
      need_a_q  <= 1'b0;
      need_b_q  <= 1'b0;
      reg2loc_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      dst_q     <= dst_d;
      need_a_q  <= need_a_d;
      need_b_q  <= need_b_d;
      reg2loc_q <= reg2loc_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    rd_addr     = '0;
    op_valid    = 1'b0;
    if (rst_n) begin
`ifdef SEQ_BYPASS_EN
      instr_ready = (state_q == IDLE) || ((state_q == OUT) && op_ready);
`else
      instr_ready = (state_q == IDLE);
`endif
    end
    case (state_q)
      RD_A:    rd_addr = rn_q;
      RD_B:    rd_addr = reg2loc_q ? dst_q : rm_q;
      OUT:     op_valid = 1'b1;
      default: ;
    endcase
  end

  assign reg2loc = reg2loc_q;
  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign op_dst  = dst_q;

endmodule

// File: tb/tb_reg_read_sequencer.sv
// Scoreboard bench for reg_read_sequencer: a register-file model answers reads one cycle late.
// Expected operands and latency are queued at issue and checked when op_valid appears.
module tb_reg_read_sequencer;
  localparam int DATA_W = 64;
`ifdef SEQ_BYPASS_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic              clk, rst_n, instr_valid, instr_ready, reg2loc, op_valid, op_ready;
  logic [31:0]       instr;
  logic [4:0]        rd_addr, op_dst;
  logic [DATA_W-1:0] rd_data, op_a, op_b;
  logic [DATA_W-1:0] regs [32];

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        dst;
    logic [4:0]        addr1;
    logic [4:0]        addr2;
    logic              r2l;
    int                lat;
    int                nrd;
  } exp_t;

  exp_t sb[$];

  reg_read_sequencer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rd_addr(rd_addr), .reg2loc(reg2loc), .rd_data(rd_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_dst(op_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with a registered read port.
  always @(posedge clk) rd_data <= regs[rd_addr];

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    bit na, nb;
    logic [4:0] bsel;
    na = 1'b1; nb = 1'b1; e.r2l = 1'b0;
    if (w[31:21] == 11'h7C0) e.r2l = 1'b1;
    else if (w[31:21] == 11'h7C2) nb = 1'b0;
    else if (w[31:24] == 8'hB4) begin na = 1'b0; e.r2l = 1'b1; end
    else if (w[31:26] == 6'b000101) begin na = 1'b0; nb = 1'b0; end
    bsel    = e.r2l ? w[4:0] : w[20:16];
    e.dst   = w[4:0];
    e.a     = na ? regs[w[9:5]] : '0;
    e.b     = nb ? regs[bsel] : '0;
    e.nrd   = int'(na) + int'(nb);
    e.lat   = (na && nb) ? 4 : ((na || nb) ? 3 : 1);
    e.addr1 = na ? w[9:5] : (nb ? bsel : 5'd0);
    e.addr2 = (na && nb) ? bsel : 5'd0;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; op_ready = 1'b0; instr = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b0 || op_valid !== 1'b0 || rd_addr !== 5'd0 || reg2loc !== 1'b0 ||
        op_a !== '0 || op_b !== '0 || op_dst !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b addr=%0d r2l=%b a=%h b=%h dst=%0d, expected all 0",
               instr_ready, op_valid, rd_addr, reg2loc, op_a, op_b, op_dst);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b1 || op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", instr_ready, op_valid);
    end
  endtask

  // One instruction from IDLE through op handshake, tracing every cycle.
  task automatic run_one(input logic [31:0] w);
    exp_t e;
    bit seen;
    logic [4:0] exp_addr;
    @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: got %b, expected 1", instr_ready);
    end
    instr = w; instr_valid = 1'b1; op_ready = 1'b1;
    sb.push_back(model(w));
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    e = sb[0];
    seen = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      exp_addr = (c == 1) ? e.addr1 : ((c == 2 && e.nrd == 2) ? e.addr2 : 5'd0);
      vectors++;
      if (rd_addr !== exp_addr || reg2loc !== e.r2l) begin
        miscompares++;
        $display("FAIL trace %h c%0d: got addr=%0d r2l=%b, expected addr=%0d r2l=%b",
                 w, c, rd_addr, reg2loc, exp_addr, e.r2l);
      end
      if (op_valid === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        vectors++;
        if (c != e.lat) begin
          miscompares++;
          $display("FAIL latency %h: got %0d, expected %0d", w, c, e.lat);
        end
        vectors++;
        if (op_a !== e.a || op_b !== e.b || op_dst !== e.dst) begin
          miscompares++;
          $display("FAIL operands %h: got a=%h b=%h dst=%0d, expected a=%h b=%h dst=%0d",
                   w, op_a, op_b, op_dst, e.a, e.b, e.dst);
        end
        $display("txn instr=%h a=%h b=%h dst=%0d lat=%0d", w, op_a, op_b, op_dst, c);
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout %h: got no op_valid, expected one after %0d cycles", w, e.lat);
      void'(sb.pop_front());
    end
    @(negedge clk);
    vectors++;
    if (op_valid !== 1'b0 || reg2loc !== 1'b0 || rd_addr !== 5'd0 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_idle %h: got vld=%b r2l=%b addr=%0d rdy=%b, expected 0 0 0 1",
               w, op_valid, reg2loc, rd_addr, instr_ready);
    end
  endtask

  task automatic test_decode();
    logic [31:0] table_w [7];
    table_w = '{32'h8B020023, 32'hF8000085, 32'hB4000007, 32'h14000000,
                32'hF840018A, 32'hCB1401B1, 32'hB40001FE};
    foreach (table_w[i]) run_one(table_w[i]);
    run_one(32'h17FFFFFF);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int c, gap;
    op_ready = 1'b0;
    @(negedge clk);
    instr = 32'h8B020023; instr_valid = 1'b1;
    sb.push_back(model(instr));
    @(negedge clk);
    instr = 32'h8B0800C9;
    c = 1;
    while (op_valid !== 1'b1 && c < 8) begin @(negedge clk); c++; end
    e = sb.pop_front();
    vectors++;
    if (op_valid !== 1'b1 || c != e.lat) begin
      miscompares++;
      $display("FAIL bp_latency: got vld=%b at %0d, expected vld=1 at %0d", op_valid, c, e.lat);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (op_valid !== 1'b1 || op_a !== e.a || op_b !== e.b || op_dst !== e.dst || instr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold k%0d: got vld=%b a=%h b=%h dst=%0d rdy=%b, expected 1 %h %h %0d 0",
                 k, op_valid, op_a, op_b, op_dst, instr_ready, e.a, e.b, e.dst);
      end
      @(negedge clk);
    end
    $display("txn instr=8b020023 a=%h b=%h dst=%0d held=5", op_a, op_b, op_dst);
    sb.push_back(model(32'h8B0800C9));
    op_ready = 1'b1;
    @(negedge clk);
    gap = 0;
    while (rd_addr !== 5'd6 && gap < 4) begin gap++; @(negedge clk); end
    instr_valid = 1'b0;
    vectors++;
    if (gap != EXP_GAP) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d idle cycles, expected %0d", gap, EXP_GAP);
    end
    c = 1;
    while (op_valid !== 1'b1 && c < 8) begin @(negedge clk); c++; end
    e = sb.pop_front();
    vectors++;
    if (op_valid !== 1'b1 || c != e.lat || op_a !== e.a || op_b !== e.b || op_dst !== e.dst) begin
      miscompares++;
      $display("FAIL b2b_second: got vld=%b lat=%0d a=%h b=%h dst=%0d, expected 1 %0d %h %h %0d",
               op_valid, c, op_a, op_b, op_dst, e.lat, e.a, e.b, e.dst);
    end
    $display("txn instr=8b0800c9 a=%h b=%h dst=%0d gap=%0d", op_a, op_b, op_dst, gap);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ghost;
    @(negedge clk);
    instr = 32'h8B020023; instr_valid = 1'b1; op_ready = 1'b1;
    sb.push_back(model(instr));
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_addr !== 5'd2) begin
      miscompares++;
      $display("FAIL mid_rd_b: got addr=%0d, expected 2", rd_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_ready !== 1'b0 || op_valid !== 1'b0 || rd_addr !== 5'd0 || reg2loc !== 1'b0 ||
        op_a !== '0 || op_b !== '0 || op_dst !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b addr=%0d r2l=%b a=%h b=%h dst=%0d, expected all 0",
               instr_ready, op_valid, rd_addr, reg2loc, op_a, op_b, op_dst);
    end
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ghost = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (op_valid !== 1'b0) ghost = 1'b1;
    end
    vectors++;
    if (ghost) begin
      miscompares++;
      $display("FAIL abandoned_instr: got op_valid after reset, expected none");
    end
    $display("txn instr=8b020023 abandoned by reset");
    run_one(32'hF8000085);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[1] = 64'h11;
    regs[2] = 64'h22;
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_read_sequencer.md
REG_READ_SEQUENCER -- requirements
Module: reg_read_sequencer

Interface
REQ-001 Parameter: DATA_W, 64, register data width.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: instr_valid  input  1  instruction offered.
REQ-005 Port: instr_ready  output  1  sequencer can accept an instruction.
REQ-006 Port: instr  input  32  LEGv8 instruction word.
REQ-007 Port: rd_addr  output  5  register-file read-port address.
REQ-008 Port: reg2loc  output  1  operand-B field select: 0 = Rm (instr[20:16]), 1 = Rt (instr[4:0]).
REQ-009 Port: rd_data  input  DATA_W  register-file read data, valid one cycle after rd_addr.
REQ-010 Port: op_valid  output  1  operands ready.
REQ-011 Port: op_ready  input  1  consumer accepts operands.
REQ-012 Port: op_a / op_b  output  DATA_W each  operand A (from Rn) / operand B (from Rm or Rt).
REQ-013 Port: op_dst  output  5  instr[4:0] of the accepted instruction.

Function
REQ-014 Accept handshake SHALL occur on a rising edge with instr_valid && instr_ready; instr SHALL be latched then; instr_ready SHALL be 1 only in IDLE (see REQ-027).
REQ-015 Decode of the latched word SHALL be: STUR (instr[31:21]=11'h7C0) needs A and B, reg2loc=1; LDUR (11'h7C2) needs A only; CBZ (instr[31:24]=8'hB4) needs B only, reg2loc=1; B (instr[31:26]=6'b000101) needs neither; all others need A and B, reg2loc=0.
REQ-016 States SHALL be IDLE, RD_A, RD_B, CAP, OUT.
REQ-017 IDLE -> RD_A on accept if A needed; else -> RD_B if B needed; else -> OUT.
REQ-018 RD_A: rd_addr=Rn (instr[9:5]); next -> RD_B if B needed, else -> CAP.
REQ-019 RD_B: rd_addr = reg2loc ? Rt : Rm; if A needed, op_a SHALL capture rd_data at the end of this cycle; next -> CAP.
REQ-020 CAP: op_b captures rd_data if B needed, else op_a captures rd_data; next -> OUT.
REQ-021 OUT: op_valid=1; op_a, op_b, op_dst SHALL hold stable until op_valid && op_ready; then -> IDLE.
REQ-022 Unneeded operands SHALL be driven 0; rd_addr SHALL be 0 outside RD_A/RD_B; reg2loc SHALL reflect the latched instruction from accept until leaving OUT, 0 in IDLE.
REQ-023 Latency from accept edge to op_valid high SHALL be 4 cycles (A+B), 3 cycles (single operand), 1 cycle (none).
REQ-024 instr changes while not in IDLE SHALL have no effect; op_ready outside OUT SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, op_valid=0, op_a=op_b=0, op_dst=0, rd_addr=0, reg2loc=0; instr_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-026 Reset mid-sequence SHALL abandon the instruction; no op_valid SHALL be produced for it.

Configuration
REQ-027 Macro SEQ_BYPASS_EN: when defined, instr_ready SHALL also be 1 in OUT while op_ready=1, so an instruction accepted on the op handshake edge enters its first state directly (zero bubble); when undefined, one IDLE cycle SHALL separate consecutive instructions.

Verification
REQ-028 ADD X3,X1,X2 (0x8B020023), rd_data=X1 then X2 values 0x11/0x22 -> rd_addr 1 then 2, reg2loc=0, op_valid 4 cycles after accept, op_a=0x11, op_b=0x22, op_dst=3.
REQ-029 STUR X5,[X4] (0xF8000085) -> rd_addr 4 then 5, reg2loc=1, op_a=Reg[4], op_b=Reg[5], op_dst=5.
REQ-030 CBZ X7 (0xB4000007) -> single read rd_addr 7, reg2loc=1, op_a=0, op_b=Reg[7], op_valid 3 cycles after accept; B (0x14000000) -> no reads, op_valid 1 cycle after accept, op_a=op_b=0.
REQ-031 op_ready held 0 for 5 cycles in OUT -> op_valid and operands stable throughout; instr_ready=0 throughout; with SEQ_BYPASS_EN, second ADD offered during OUT accepted on the op_ready edge with no IDLE cycle, otherwise exactly one IDLE cycle.
REQ-032 rst_n pulsed low during RD_B of an ADD -> all outputs 0 immediately, no op_valid for that instruction, next instruction processed normally.
